// File: rtl/pcu_boot_ctrl.sv
// pcu_boot_ctrl: host byte loader for PCU program RAM plus hold/run/pause/step sequencing of PCU rst/ce
module pcu_boot_ctrl #(
  parameter int AW       = 14,
  parameter bit BOOT_RUN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    hdata,
  input  logic          hstb,
  input  logic          hcmd,
  output logic          hbusy,
  output logic [AW-1:0] pm_waddr,
  output logic [15:0]   pm_wdata,
  output logic          pm_we,
  output logic          cpu_rst,
  output logic          cpu_ce,
  output logic [15:0]   cksum,
  output logic          err
);
  typedef enum logic [1:0] {HOLD, RUN, PAUSE, STEP} mode_t;
  typedef enum logic [2:0] {L_CMD, L_AH, L_AL, L_DH, L_DL, L_WR} ld_t;

  localparam mode_t MODE_RST = BOOT_RUN ? RUN : HOLD;

  mode_t         mode_q, mode_d;
  ld_t           ld_q, ld_d;
  logic [7:0]    ah_q, ah_d;
  logic [7:0]    dh_q, dh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   cksum_q, cksum_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          crst_q, crst_d;
  logic          cce_q, cce_d;
  mode_t         cmode;

  // Next-state: a STEP lasts one cycle and decodes commands as PAUSE; the write cycle drops all strobes
  always_comb begin
    mode_d  = (mode_q == STEP) ? PAUSE : mode_q;
    cmode   = (mode_q == STEP) ? PAUSE : mode_q;
    ld_d    = ld_q;
    ah_d    = ah_q;
    dh_d    = dh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cksum_d = cksum_q;
    err_d   = err_q;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    if (ld_q == L_WR) begin
      addr_d = addr_q + AW'(1);
      ld_d   = L_DH;
      err_d  = err_q | hstb;
    end else if (hstb && hcmd) begin
      ld_d = L_CMD;
      case (hdata)
        8'h01: begin
          ld_d    = (cmode == HOLD) ? L_AH : L_CMD;
          cksum_d = (cmode == HOLD) ? 16'h0 : cksum_q;
          err_d   = err_q | (cmode != HOLD);
        end
        8'h02: mode_d = RUN;
        8'h03: begin
          mode_d = HOLD;
          err_d  = 1'b0;
        end
        8'h04: mode_d = (cmode == RUN) ? RUN : STEP;
        8'h05: mode_d = (cmode == RUN) ? PAUSE : cmode;
        default: err_d = 1'b1;
      endcase
    end else if (hstb) begin
      case (ld_q)
        L_AH: begin
          ah_d = hdata;
          ld_d = L_AL;
        end
        L_AL: begin
          addr_d = AW'({ah_q, hdata});
          ld_d   = L_DH;
        end
        L_DH: begin
          dh_d = hdata;
          ld_d = L_DL;
        end
        L_DL: begin
          we_d    = (mode_q == HOLD);
          busy_d  = (mode_q == HOLD);
          wdata_d = (mode_q == HOLD) ? {dh_q, hdata} : wdata_q;
          cksum_d = (mode_q == HOLD) ? cksum_q + {dh_q, hdata} : cksum_q;
          ld_d    = (mode_q == HOLD) ? L_WR : L_CMD;
        end
        default: err_d = 1'b1;
      endcase
    end
    crst_d = (mode_d == HOLD);
    cce_d  = (mode_d == RUN) || (mode_d == STEP);
  end

  // State and registered outputs; async reset drops any write in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= MODE_RST;
      ld_q    <= L_CMD;
      ah_q    <= 8'h0;
      dh_q    <= 8'h0;
      addr_q  <= '0;
      wdata_q <= 16'h0;
      cksum_q <= 16'h0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= !BOOT_RUN;
      cce_q   <= BOOT_RUN;
    end else begin
      mode_q  <= mode_d;
      ld_q    <= ld_d;
      ah_q    <= ah_d;
      dh_q    <= dh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cksum_q <= cksum_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      crst_q  <= crst_d;
      cce_q   <= cce_d;
    end
  end

  assign hbusy    = busy_q;
  assign pm_waddr = addr_q;
  assign pm_wdata = wdata_q;
  assign pm_we    = we_q;
  assign cpu_rst  = crst_q;
  assign cpu_ce   = cce_q;
  assign cksum    = cksum_q;
  assign err      = err_q;
endmodule

// File: tb/tb_pcu_boot_ctrl.sv
// tb_pcu_boot_ctrl: directed scenario bench for pcu_boot_ctrl with BOOT_RUN=0
module tb_pcu_boot_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  hdata = 8'h0;
  logic        hstb = 1'b0;
  logic        hcmd = 1'b0;
  logic        hbusy, pm_we, cpu_rst, cpu_ce, err;
  logic [13:0] pm_waddr;
  logic [15:0] pm_wdata, cksum;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [13:0] wa [0:15];
  logic [15:0] wd [0:15];
  int          wn = 0;
  int          ce_n = 0;
  int          ce_adj = 0;
  int          rst_cnt = 0;
  int          ce_rst_bad = 0;
  int          we_bad = 0;
  logic        ce_prev = 1'b0;

  pcu_boot_ctrl #(.AW(14), .BOOT_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .hdata(hdata), .hstb(hstb), .hcmd(hcmd), .hbusy(hbusy),
    .pm_waddr(pm_waddr), .pm_wdata(pm_wdata), .pm_we(pm_we), .cpu_rst(cpu_rst),
    .cpu_ce(cpu_ce), .cksum(cksum), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pm_we && wn < 16) begin
      wa[wn] = pm_waddr;
      wd[wn] = pm_wdata;
      wn++;
    end
    if (cpu_ce) begin
      ce_n++;
      if (ce_prev) ce_adj++;
    end
    if (cpu_rst) rst_cnt++;
    if (cpu_ce && cpu_rst) ce_rst_bad++;
    if (pm_we && !cpu_rst) we_bad++;
    ce_prev = cpu_ce;
  end

  task automatic send(input logic c, input logic [7:0] d);
    @(negedge clk);
    hcmd = c;
    hdata = d;
    hstb = 1'b1;
    @(negedge clk);
    hstb = 1'b0;
    hcmd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(3);
    n_cmp++; if ({cpu_rst, cpu_ce, pm_we, hbusy} !== 4'b1000) begin n_bad++; $display("FAIL in_reset rst/ce/we/busy got %b want 1000", {cpu_rst, cpu_ce, pm_we, hbusy}); end
    rst = 1'b1;
    idle(5);
    n_cmp++; if ({cpu_rst, cpu_ce, err} !== 3'b100) begin n_bad++; $display("FAIL post_reset rst/ce/err got %b want 100", {cpu_rst, cpu_ce, err}); end
    n_cmp++; if (cksum !== 16'h0) begin n_bad++; $display("FAIL post_reset cksum got %h want 0000", cksum); end
    n_cmp++; if ({pm_we, hbusy, pm_waddr, pm_wdata} !== 32'h0) begin n_bad++; $display("FAIL post_reset we/busy/addr/data got %h want 0", {pm_we, hbusy, pm_waddr, pm_wdata}); end
  endtask

  task automatic test_load;
    wn = 0;
    send(1, 8'h01); send(0, 8'h00); send(0, 8'h10); send(0, 8'h40); send(0, 8'h10);
    n_cmp++; if ({pm_we, hbusy} !== 2'b11) begin n_bad++; $display("FAIL load_pulse we/busy got %b want 11", {pm_we, hbusy}); end
    n_cmp++; if ({pm_waddr, pm_wdata} !== {14'h0010, 16'h4010}) begin n_bad++; $display("FAIL load_pulse addr/data got %h/%h want 0010/4010", pm_waddr, pm_wdata); end
    send(0, 8'h01); send(0, 8'h11);
    idle(2);
    n_cmp++; if (wn !== 2) begin n_bad++; $display("FAIL load_count got %0d want 2", wn); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1]} !== {14'h0010, 16'h4010, 14'h0011, 16'h0111}) begin n_bad++; $display("FAIL load_writes got %h:%h %h:%h want 0010:4010 0011:0111", wa[0], wd[0], wa[1], wd[1]); end
    n_cmp++; if (cksum !== 16'h4121) begin n_bad++; $display("FAIL load_cksum got %h want 4121", cksum); end
  endtask

  task automatic test_wrap;
    wn = 0;
    send(1, 8'h01);
    n_cmp++; if (cksum !== 16'h0) begin n_bad++; $display("FAIL wrap_cksum_clear got %h want 0000", cksum); end
    send(0, 8'h3F); send(0, 8'hFF); send(0, 8'hE2); send(0, 8'h00); send(0, 8'h50); send(0, 8'h00);
    idle(2);
    n_cmp++; if (wn !== 2) begin n_bad++; $display("FAIL wrap_count got %0d want 2", wn); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1]} !== {14'h3FFF, 16'hE200, 14'h0000, 16'h5000}) begin n_bad++; $display("FAIL wrap_writes got %h:%h %h:%h want 3fff:e200 0000:5000", wa[0], wd[0], wa[1], wd[1]); end
    n_cmp++; if ({cksum, err} !== {16'h3200, 1'b0}) begin n_bad++; $display("FAIL wrap_cksum_err got %h/%b want 3200/0", cksum, err); end
  endtask

  task automatic test_run_step;
    send(1, 8'h02);
    n_cmp++; if ({cpu_rst, cpu_ce} !== 2'b01) begin n_bad++; $display("FAIL run rst/ce got %b want 01", {cpu_rst, cpu_ce}); end
    send(1, 8'h05);
    n_cmp++; if ({cpu_rst, cpu_ce} !== 2'b00) begin n_bad++; $display("FAIL pause rst/ce got %b want 00", {cpu_rst, cpu_ce}); end
    ce_n = 0; ce_adj = 0; rst_cnt = 0;
    send(1, 8'h04);
    n_cmp++; if (cpu_ce !== 1'b1) begin n_bad++; $display("FAIL step_ce got %b want 1", cpu_ce); end
    idle(3);
    send(1, 8'h04);
    idle(3);
    n_cmp++; if ({ce_n, ce_adj, rst_cnt} !== {32'd2, 32'd0, 32'd0}) begin n_bad++; $display("FAIL step_cycles ce=%0d adj=%0d rst=%0d want 2/0/0", ce_n, ce_adj, rst_cnt); end
    n_cmp++; if ({cpu_rst, cpu_ce} !== 2'b00) begin n_bad++; $display("FAIL step_end rst/ce got %b want 00", {cpu_rst, cpu_ce}); end
  endtask

  task automatic test_load_in_run;
    send(1, 8'h02);
    wn = 0;
    send(1, 8'h01);
    n_cmp++; if ({err, cpu_ce} !== 2'b11) begin n_bad++; $display("FAIL load_in_run err/ce got %b want 11", {err, cpu_ce}); end
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h11); send(0, 8'h11);
    idle(2);
    n_cmp++; if (wn !== 0) begin n_bad++; $display("FAIL load_in_run_writes got %0d want 0", wn); end
    send(1, 8'h03);
    n_cmp++; if ({cpu_rst, cpu_ce, err} !== 3'b100) begin n_bad++; $display("FAIL reset_cmd rst/ce/err got %b want 100", {cpu_rst, cpu_ce, err}); end
    send(1, 8'h07);
    n_cmp++; if ({cpu_rst, err} !== 2'b11) begin n_bad++; $display("FAIL bad_cmd rst/err got %b want 11", {cpu_rst, err}); end
    send(1, 8'h03);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
  endtask

  task automatic test_abort_busy;
    wn = 0;
    send(1, 8'h01); send(0, 8'h00); send(0, 8'h20); send(0, 8'h12); send(1, 8'h02);
    idle(2);
    n_cmp++; if ({wn == 0, cpu_rst, cpu_ce, err} !== 4'b1010) begin n_bad++; $display("FAIL abort wr0/rst/ce/err got %b want 1010", {wn == 0, cpu_rst, cpu_ce, err}); end
    send(1, 8'h03); send(1, 8'h01); send(0, 8'h00); send(0, 8'h30); send(0, 8'hAB);
    @(negedge clk);
    hcmd = 1'b0; hdata = 8'hCD; hstb = 1'b1;
    @(negedge clk);
    n_cmp++; if ({pm_we, hbusy} !== 2'b11) begin n_bad++; $display("FAIL busy_window we/busy got %b want 11", {pm_we, hbusy}); end
    hdata = 8'h99;
    @(negedge clk);
    hstb = 1'b0;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL busy_drop_err got %b want 1", err); end
    send(0, 8'h11); send(0, 8'h22);
    idle(2);
    n_cmp++; if (wn !== 2) begin n_bad++; $display("FAIL busy_count got %0d want 2", wn); end
    n_cmp++; if ({wa[0], wd[0], wa[1], wd[1]} !== {14'h0030, 16'hABCD, 14'h0031, 16'h1122}) begin n_bad++; $display("FAIL busy_writes got %h:%h %h:%h want 0030:abcd 0031:1122", wa[0], wd[0], wa[1], wd[1]); end
    n_cmp++; if (cksum !== 16'hBCEF) begin n_bad++; $display("FAIL busy_cksum got %h want bcef", cksum); end
  endtask

  task automatic test_async_reset;
    send(0, 8'h55);
    @(negedge clk);
    hcmd = 1'b0; hdata = 8'h66; hstb = 1'b1;
    @(negedge clk);
    hstb = 1'b0;
    n_cmp++; if ({pm_we, pm_waddr, pm_wdata} !== {1'b1, 14'h0032, 16'h5566}) begin n_bad++; $display("FAIL pre_async we/addr/data got %b/%h/%h want 1/0032/5566", pm_we, pm_waddr, pm_wdata); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({pm_we, hbusy, cpu_rst, cksum, pm_waddr} !== {3'b001, 16'h0, 14'h0}) begin n_bad++; $display("FAIL async_reset we/busy/rst/cksum/addr got %b%b%b/%h/%h want 001/0000/0000", pm_we, hbusy, cpu_rst, cksum, pm_waddr); end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    wn = 0;
    send(0, 8'h77);
    idle(2);
    n_cmp++; if ({err, wn == 0} !== 2'b11) begin n_bad++; $display("FAIL post_async_loader err/nowrite got %b want 11", {err, wn == 0}); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_wrap;
    test_run_step;
    test_load_in_run;
    test_abort_busy;
    test_async_reset;
    n_cmp++; if ({ce_rst_bad, we_bad} !== 64'h0) begin n_bad++; $display("FAIL invariants ce_with_rst=%0d we_outside_hold=%0d want 0/0", ce_rst_bad, we_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
